trap_entry_ctrl: RTL
====================

Name: trap_entry_ctrl

Overview:
- Producer side of the trap base register (TBR) and trap vector address.
- Collects synchronous exceptions, Ticc software traps and external interrupts, and priority-encodes them to an 8-bit tt.
- Writes tt into TBR[11:4] and sequences SPARC V8 trap entry: window decrement, S/ET update, PC/nPC save into l1/l2, fetch redirect to TBR.
- Sits between the pipeline exception flags and the fetch unit, register file and PSR.

Parameters:
- NWINDOWS, 8, number of register windows; CWP arithmetic is modulo NWINDOWS.
- TBA_RESET, 20'h00000, value loaded into TBR[31:12] at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exc_vec  in  9  sync exception flags, priority high to low, with tt:
  - [0] inst_access 0x01
  - [1] privileged 0x03
  - [2] illegal 0x02
  - [3] fp_disabled 0x04
  - [4] win_overflow 0x05
  - [5] win_underflow 0x06
  - [6] mem_not_aligned 0x07
  - [7] data_access 0x09
  - [8] tag_overflow 0x0A
- ticc_valid  in  1  Ticc taken this cycle.
- ticc_num  in  7  software trap number.
- irq_level  in  4  external interrupt level; 0 means none.
- pil  in  4  PSR.PIL.
- et  in  1  PSR.ET.
- cwp  in  5  current window pointer.
- pc  in  32  PC of the trapping instruction.
- npc  in  32  nPC of the trapping instruction.
- tba_we  in  1  WRTBR strobe.
- tba_wdata  in  20  new TBA value.
- tbr  out  32  {TBA, tt, 4'b0000}.
- trap_busy  out  1  high while the FSM is not in IDLE or ERROR.
- cwp_we  out  1  write strobe for the new CWP.
- cwp_new  out  5  (cwp-1) mod NWINDOWS.
- s_set  out  1  PSR.PS <= S, S <= 1.
- et_clr  out  1  ET <= 0.
- rf_we  out  1  register file write strobe.
- rf_waddr  out  5  window-relative register address.
- rf_wdata  out  32  register file write data.
- redirect_valid  out  1  fetch redirect strobe.
- redirect_addr  out  32  fetch redirect target.
- error_mode  out  1  sticky error state.

Behaviour:
- Reset (async, any state):
  - state <= IDLE.
  - tbr <= {TBA_RESET, 8'h00, 4'h0}.
  - All strobes 0, error_mode 0; latched pc/npc/cwp cleared.
  - Reset in mid-sequence aborts the entry; no further rf_we or redirect is issued.
- tba_we:
  - Writes TBR[31:12] on the next edge in any state, including during a trap.
  - Never touches tt.
  - Simultaneous with tt capture, both fields update.
- Priority: lowest set exc_vec bit, then Ticc (tt = {1'b1, ticc_num}), then interrupt (tt = {4'h1, irq_level}).
- Interrupt acceptance: taken only if et=1, irq_level!=0, and (irq_level==15 or irq_level>pil). Otherwise ignored; it never causes ERROR.
- States:
  - IDLE: on an edge with a qualifying request and et=1, capture tt into tbr[11:4], latch pc, npc and cwp, go to WIN. A sync exception or Ticc with et=0 goes to ERROR.
  - WIN (N+1): cwp_we=1 with cwp_new; s_set=1; et_clr=1.
  - SAVE_PC (N+2): rf_we=1, rf_waddr=17, rf_wdata=latched pc.
  - SAVE_NPC (N+3): rf_we=1, rf_waddr=18, rf_wdata=latched npc.
  - VECTOR (N+4): redirect_valid=1, redirect_addr=tbr. Return to IDLE on the next edge.
  - ERROR: error_mode=1 and all strobes 0. Left only via rst_n.
- All strobes are single-cycle pulses, registered outputs.
- trap_busy is high N+1..N+4. Requests arriving while busy are ignored; upstream holds or reissues them after the flush.
- CWP wrap: cwp=0 gives cwp_new=NWINDOWS-1.
- Back-to-back: a request present in the IDLE cycle right after VECTOR is accepted normally.

Decomposition:
- Package trap_pkg holds:
  - tt constants: TT_INST_ACCESS, TT_PRIV, TT_ILLEGAL, TT_FP_DIS, TT_WOVF, TT_WUNF, TT_ALIGN, TT_DACC, TT_TAG, TT_IRQ_BASE 8'h10, TT_TICC_BASE 8'h80.
  - FSM state encoding.
  - Register indices L1=17, L2=18.
- One combinational sub-module, trap_prio_enc: inputs exc_vec, ticc_valid, ticc_num, irq_level, pil, et; outputs req, tt, sync_req.

Test Plan:
- Reset with TBA_RESET=0 -> tbr=0x00000000, all strobes 0. tba_we with 0x00010 -> tbr=0x00010000 next edge.
- exc_vec=9'h004, et=1, cwp=0, pc=0x40000100, npc=0x40000104 -> tt=0x02, and in order:
  - N+1: cwp_we with cwp_new=7, s_set, et_clr.
  - N+2: rf r17=0x40000100.
  - N+3: rf r18=0x40000104.
  - N+4: redirect 0x00010020.
- exc_vec=9'h006 with ticc_valid=1 and irq_level=9 -> tt=0x03 only.
- Interrupt masking:
  - irq_level=5, pil=5 -> no trap.
  - pil=4 -> tt=0x15, redirect 0x00010150.
  - irq_level=15, pil=15 -> tt=0x1F.
- ticc_num=0x10 alone -> tt=0x90, redirect 0x00010900. tba_we=0x00020 issued during WIN -> redirect 0x00020900.
- Error and reset cases:
  - exc_vec=9'h100 with et=0 -> error_mode=1 sticky, no strobes, later requests ignored.
  - rst_n low clears it.
  - rst_n pulsed during SAVE_PC -> no r18 write, no redirect.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared trap-entry definitions: trap type codes, FSM encoding and window register indices.
package trap_pkg;

  localparam int unsigned TT_W      = 8;
  localparam int unsigned EXC_W     = 9;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned TBA_W     = 20;

  localparam logic [TT_W-1:0] TT_INST_ACCESS = 8'h01;
  localparam logic [TT_W-1:0] TT_PRIV        = 8'h03;
  localparam logic [TT_W-1:0] TT_ILLEGAL     = 8'h02;
  localparam logic [TT_W-1:0] TT_FP_DIS      = 8'h04;
  localparam logic [TT_W-1:0] TT_WOVF        = 8'h05;
  localparam logic [TT_W-1:0] TT_WUNF        = 8'h06;
  localparam logic [TT_W-1:0] TT_ALIGN       = 8'h07;
  localparam logic [TT_W-1:0] TT_DACC        = 8'h09;
  localparam logic [TT_W-1:0] TT_TAG         = 8'h0A;
  localparam logic [TT_W-1:0] TT_IRQ_BASE    = 8'h10;
  localparam logic [TT_W-1:0] TT_TICC_BASE   = 8'h80;

  localparam logic [RF_ADDR_W-1:0] L1 = 5'd17;
  localparam logic [RF_ADDR_W-1:0] L2 = 5'd18;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WIN      = 3'd1,
    ST_SAVE_PC  = 3'd2,
    ST_SAVE_NPC = 3'd3,
    ST_VECTOR   = 3'd4,
    ST_ERROR    = 3'd5
  } trap_state_e;

  // Lowest set flag wins; returns 0 when no flag is set.
  function automatic logic [TT_W-1:0] exc_tt(input logic [EXC_W-1:0] v);
    logic [TT_W-1:0] t;
    t = '0;
    casez (v)
      9'b????????1: t = TT_INST_ACCESS;
      9'b???????10: t = TT_PRIV;
      9'b??????100: t = TT_ILLEGAL;
      9'b?????1000: t = TT_FP_DIS;
      9'b????10000: t = TT_WOVF;
      9'b???100000: t = TT_WUNF;
      9'b??1000000: t = TT_ALIGN;
      9'b?10000000: t = TT_DACC;
      9'b100000000: t = TT_TAG;
      default:      t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Priority encoder: sync exceptions, then Ticc, then qualified interrupts, reduced to one tt.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic [EXC_W-1:0] exc_vec,
  input  logic             ticc_valid,
  input  logic [6:0]       ticc_num,
  input  logic [3:0]       irq_level,
  input  logic [3:0]       pil,
  input  logic             et,
  output logic             req,
  output logic [TT_W-1:0]  tt,
  output logic             sync_req
);

  logic irq_ok;

  always_comb begin
    tt       = '0;
    // Level 15 is non-maskable by PIL but still gated by ET.
    irq_ok   = et && (irq_level != 4'h0) && ((irq_level == 4'hF) || (irq_level > pil));
    sync_req = (|exc_vec) || ticc_valid;
    req      = sync_req || irq_ok;
    if (|exc_vec)
      tt = exc_tt(exc_vec);
    else if (ticc_valid)
      tt = TT_TICC_BASE | {1'b0, ticc_num};
    else if (irq_ok)
      tt = TT_IRQ_BASE | {4'h0, irq_level};
  end

endmodule

// File: rtl/trap_entry_ctrl.sv
// Trap entry sequencer: owns TBR and drives window, PSR, l1/l2 save and fetch redirect.
module trap_entry_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned      NWINDOWS  = 8,
  parameter logic [TBA_W-1:0] TBA_RESET = 20'h00000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXC_W-1:0]     exc_vec,
  input  logic                 ticc_valid,
  input  logic [6:0]           ticc_num,
  input  logic [3:0]           irq_level,
  input  logic [3:0]           pil,
  input  logic                 et,
  input  logic [4:0]           cwp,
  input  logic [31:0]          pc,
  input  logic [31:0]          npc,
  input  logic                 tba_we,
  input  logic [TBA_W-1:0]     tba_wdata,
  output logic [31:0]          tbr,
  output logic                 trap_busy,
  output logic                 cwp_we,
  output logic [4:0]           cwp_new,
  output logic                 s_set,
  output logic                 et_clr,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_addr,
  output logic                 error_mode
);

  logic            enc_req;
  logic            enc_sync;
  logic [TT_W-1:0] enc_tt;

  trap_prio_enc u_prio (
    .exc_vec    (exc_vec),
    .ticc_valid (ticc_valid),
    .ticc_num   (ticc_num),
    .irq_level  (irq_level),
    .pil        (pil),
    .et         (et),
    .req        (enc_req),
    .tt         (enc_tt),
    .sync_req   (enc_sync)
  );

  trap_state_e state_q, state_d;
  logic        capture;

  logic [31:0] pc_q, pc_d, npc_q, npc_d, tbr_d;
  logic [4:0]  cwp_q, cwp_d, cwp_dec;

  logic                 trap_busy_d, cwp_we_d, s_set_d, et_clr_d, rf_we_d;
  logic                 redirect_valid_d, error_mode_d;
  logic [4:0]           cwp_new_d;
  logic [RF_ADDR_W-1:0] rf_waddr_d;
  logic [31:0]          rf_wdata_d, redirect_addr_d;

  // State, latched context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      npc_q          <= '0;
      cwp_q          <= '0;
      tbr            <= {TBA_RESET, 8'h00, 4'h0};
      trap_busy      <= 1'b0;
      cwp_we         <= 1'b0;
      cwp_new        <= '0;
      s_set          <= 1'b0;
      et_clr         <= 1'b0;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      error_mode     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      npc_q          <= npc_d;
      cwp_q          <= cwp_d;
      tbr            <= tbr_d;
      trap_busy      <= trap_busy_d;
      cwp_we         <= cwp_we_d;
      cwp_new        <= cwp_new_d;
      s_set          <= s_set_d;
      et_clr         <= et_clr_d;
      rf_we          <= rf_we_d;
      rf_waddr       <= rf_waddr_d;
      rf_wdata       <= rf_wdata_d;
      redirect_valid <= redirect_valid_d;
      redirect_addr  <= redirect_addr_d;
      error_mode     <= error_mode_d;
    end
  end

  // Next state; et=0 can only leave req high for a sync exception or Ticc.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_req && et) begin
          capture = 1'b1;
          state_d = ST_WIN;
        end else if (enc_sync && !et) begin
          state_d = ST_ERROR;
        end
      end
      ST_WIN:      state_d = ST_SAVE_PC;
      ST_SAVE_PC:  state_d = ST_SAVE_NPC;
      ST_SAVE_NPC: state_d = ST_VECTOR;
      ST_VECTOR:   state_d = ST_IDLE;
      ST_ERROR:    state_d = ST_ERROR;
      default:     state_d = ST_ERROR;
    endcase
  end

  // Outputs are computed from the upcoming state and data so the registers line up with it.
  always_comb begin
    pc_d    = capture ? pc  : pc_q;
    npc_d   = capture ? npc : npc_q;
    cwp_d   = capture ? cwp : cwp_q;
    tbr_d   = {tba_we ? tba_wdata : tbr[31:12], capture ? enc_tt : tbr[11:4], 4'h0};
    cwp_dec = (cwp_d == 5'd0) ? 5'(NWINDOWS - 1) : cwp_d - 5'd1;

    trap_busy_d      = 1'b0;
    cwp_we_d         = 1'b0;
    cwp_new_d        = '0;
    s_set_d          = 1'b0;
    et_clr_d         = 1'b0;
    rf_we_d          = 1'b0;
    rf_waddr_d       = '0;
    rf_wdata_d       = '0;
    redirect_valid_d = 1'b0;
    redirect_addr_d  = '0;
    error_mode_d     = 1'b0;

    unique case (state_d)
      ST_WIN: begin
        trap_busy_d = 1'b1;
        cwp_we_d    = 1'b1;
        cwp_new_d   = cwp_dec;
        s_set_d     = 1'b1;
        et_clr_d    = 1'b1;
      end
      ST_SAVE_PC: begin
        trap_busy_d = 1'b1;
        rf_we_d     = 1'b1;
        rf_waddr_d  = L1;
        rf_wdata_d  = pc_d;
      end
      ST_SAVE_NPC: begin
        trap_busy_d = 1'b1;
        rf_we_d     = 1'b1;
        rf_waddr_d  = L2;
        rf_wdata_d  = npc_d;
      end
      ST_VECTOR: begin
        trap_busy_d      = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_addr_d  = tbr_d;
      end
      ST_ERROR: error_mode_d = 1'b1;
      default: ;
    endcase
  end

endmodule
